// File: rtl/reg_wb_skid.sv
// reg_wb_skid: writeback stage that formats load data and buffers results in a
// two-entry skid FIFO in front of the register file.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   valid_i / ready_o        upstream handshake (ready_o depends only on state)
//   data_mem_i, addr_lo_i    raw memory word and byte offset within it
//   data_alu_i, is_load_i    ALU result and load/ALU select
//   load_code_i              RISC-V load funct3
//   addr_reg_wr_i            destination register
//   reg_wr_en_i              beat writes the register file
//   flush_i                  drop buffered entries and the incoming beat
//   data_bypass_o            combinational formatted result of the input beat
//   valid_o / ready_i        downstream handshake
//   addr_reg_wr_o, data_reg_wr_o, reg_wr_en_o   head entry fields
module reg_wb_skid #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  localparam int OW  = $clog2(XLEN/8)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] data_mem_i,
  input  logic [OW-1:0]   addr_lo_i,
  input  logic [XLEN-1:0] data_alu_i,
  input  logic            is_load_i,
  input  logic [2:0]      load_code_i,
  input  logic [AW-1:0]   addr_reg_wr_i,
  input  logic            reg_wr_en_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] data_bypass_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [AW-1:0]   addr_reg_wr_o,
  output logic [XLEN-1:0] data_reg_wr_o,
  output logic            reg_wr_en_o
);

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            wr_en;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} cnt_t;

  cnt_t            cnt;
  entry_t          slot0;  // always the head
  entry_t          slot1;
  entry_t          in_ent;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] fmt;
  logic            push;
  logic            pop;

  // Load formatting. For XLEN=32 the word/dword/unsigned-word codes all
  // collapse to the shifted word itself, so 011 and 110 need no special case.
  always_comb begin
    sh  = data_mem_i >> {addr_lo_i, 3'b000};
    fmt = sh;
    case (load_code_i)
      3'b000: begin fmt = {XLEN{sh[7]}};  fmt[7:0]  = sh[7:0];  end
      3'b001: begin fmt = {XLEN{sh[15]}}; fmt[15:0] = sh[15:0]; end
      3'b010: begin fmt = {XLEN{sh[31]}}; fmt[31:0] = sh[31:0]; end
      3'b100: begin fmt = '0;             fmt[7:0]  = sh[7:0];  end
      3'b101: begin fmt = '0;             fmt[15:0] = sh[15:0]; end
      3'b110: begin fmt = '0;             fmt[31:0] = sh[31:0]; end
      default: fmt = sh;
    endcase
  end

  assign data_bypass_o = is_load_i ? fmt : data_alu_i;

  assign in_ent.addr  = addr_reg_wr_i;
  assign in_ent.data  = data_bypass_o;
  assign in_ent.wr_en = reg_wr_en_i;

  assign ready_o = (cnt != FULL);
  assign valid_o = (cnt != EMPTY);
  assign push    = valid_i & ready_o & ~flush_i;
  assign pop     = valid_o & ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= EMPTY;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush_i) begin
      cnt   <= EMPTY;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == EMPTY) begin
            slot0 <= in_ent;
            cnt   <= ONE;
          end else begin
            slot1 <= in_ent;
            cnt   <= FULL;
          end
        end
        2'b01: begin
          slot0 <= slot1;
          slot1 <= '0;
          cnt   <= (cnt == FULL) ? ONE : EMPTY;
        end
        // push+pop only happens with one entry (FULL blocks push): replace head
        2'b11: slot0 <= in_ent;
        default: ;
      endcase
    end
  end

  assign addr_reg_wr_o = valid_o ? slot0.addr : '0;
  assign data_reg_wr_o = valid_o ? slot0.data : '0;
  assign reg_wr_en_o   = valid_o & slot0.wr_en & (slot0.addr != '0);

endmodule

// File: tb/tb_reg_wb_skid.sv
module tb_reg_wb_skid;
  logic        clk = 0;
  logic        rst = 1;
  // XLEN=32 instance
  logic        valid_i = 0, ready_i = 0, is_load_i = 0, reg_wr_en_i = 0, flush_i = 0;
  logic [31:0] data_mem_i = 0, data_alu_i = 0;
  logic [1:0]  addr_lo_i = 0;
  logic [2:0]  load_code_i = 0;
  logic [4:0]  addr_reg_wr_i = 0;
  logic        ready_o, valid_o, reg_wr_en_o;
  logic [31:0] data_bypass_o, data_reg_wr_o;
  logic [4:0]  addr_reg_wr_o;
  // XLEN=64 instance (formatting only)
  logic [63:0] m64 = 0, alu64 = 0;
  logic [2:0]  lo64 = 0, code64 = 0;
  logic        ld64 = 1;
  logic        r64_o, v64_o, we64_o;
  logic [63:0] byp64, d64_o;
  logic [4:0]  a64_o;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  reg_wb_skid #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .data_mem_i(data_mem_i), .addr_lo_i(addr_lo_i), .data_alu_i(data_alu_i),
    .is_load_i(is_load_i), .load_code_i(load_code_i), .addr_reg_wr_i(addr_reg_wr_i),
    .reg_wr_en_i(reg_wr_en_i), .flush_i(flush_i), .data_bypass_o(data_bypass_o),
    .valid_o(valid_o), .ready_i(ready_i), .addr_reg_wr_o(addr_reg_wr_o),
    .data_reg_wr_o(data_reg_wr_o), .reg_wr_en_o(reg_wr_en_o));

  reg_wb_skid #(.XLEN(64), .AW(5)) dut64 (
    .clk(clk), .rst(rst), .valid_i(1'b0), .ready_o(r64_o),
    .data_mem_i(m64), .addr_lo_i(lo64), .data_alu_i(alu64),
    .is_load_i(ld64), .load_code_i(code64), .addr_reg_wr_i(5'd0),
    .reg_wr_en_i(1'b0), .flush_i(1'b0), .data_bypass_o(byp64),
    .valid_o(v64_o), .ready_i(1'b1), .addr_reg_wr_o(a64_o),
    .data_reg_wr_o(d64_o), .reg_wr_en_o(we64_o));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference formatting from the ISA rules, plain masks and arithmetic.
  function automatic logic [63:0] sx(input logic [63:0] v, input int n);
    logic [63:0] m, b;
    m = (64'd1 << n) - 64'd1;
    b = v & m;
    if (b[n-1]) b = b | ~m;
    return b;
  endfunction

  function automatic logic [63:0] fmt(input logic [63:0] mem, input int lo,
                                      input logic [2:0] code, input int xl);
    logic [63:0] xm, s, r;
    xm = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    s  = (mem >> (8 * lo)) & xm;
    case (code)
      3'd0: r = sx(s, 8);
      3'd1: r = sx(s, 16);
      3'd2: r = sx(s, 32);
      3'd4: r = s & 64'hFF;
      3'd5: r = s & 64'hFFFF;
      3'd6: r = s & 64'hFFFF_FFFF;
      default: r = s;
    endcase
    return r & xm;
  endfunction

  typedef struct { logic [4:0] a; logic [63:0] d; logic w; } ent_t;
  ent_t q[$];

  // Compare process: checks outputs against the queue model, then advances it
  // with the inputs that the coming rising edge will see.
  always @(negedge clk) begin
    logic [63:0] exp_b;
    ent_t e;
    logic push, pop;
    exp_b = is_load_i ? fmt({32'd0, data_mem_i}, int'(addr_lo_i), load_code_i, 32)
                      : {32'd0, data_alu_i};
    chk("bypass32", {32'd0, data_bypass_o}, exp_b);
    chk("bypass64", byp64, ld64 ? fmt(m64, int'(lo64), code64, 64) : alu64);
    if (rst) begin
      q.delete();
      chk("rst_valid", {63'd0, valid_o}, 64'd0);
      chk("rst_ready", {63'd0, ready_o}, 64'd1);
      chk("rst_wen", {63'd0, reg_wr_en_o}, 64'd0);
      chk("rst_data", {32'd0, data_reg_wr_o}, 64'd0);
    end else begin
      chk("valid_o", {63'd0, valid_o}, {63'd0, q.size() != 0});
      chk("ready_o", {63'd0, ready_o}, {63'd0, q.size() != 2});
      if (q.size() != 0) begin
        chk("addr_o", {59'd0, addr_reg_wr_o}, {59'd0, q[0].a});
        chk("data_o", {32'd0, data_reg_wr_o}, q[0].d);
        chk("wen_o", {63'd0, reg_wr_en_o}, {63'd0, q[0].w && q[0].a != 0});
      end else begin
        chk("addr_idle", {59'd0, addr_reg_wr_o}, 64'd0);
        chk("data_idle", {32'd0, data_reg_wr_o}, 64'd0);
        chk("wen_idle", {63'd0, reg_wr_en_o}, 64'd0);
      end
      push = valid_i && q.size() < 2 && !flush_i;
      pop  = q.size() > 0 && ready_i;
      if (flush_i) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          e.a = addr_reg_wr_i; e.d = exp_b; e.w = reg_wr_en_i;
          q.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [4:0] rd, input logic [31:0] alu);
    valid_i = 1; is_load_i = 0; data_alu_i = alu; addr_reg_wr_i = rd; reg_wr_en_i = 1;
  endtask

  initial begin
    #1;
    chk("lit_reset_valid", {63'd0, valid_o}, 64'd0);
    chk("lit_reset_ready", {63'd0, ready_o}, 64'd1);
    step(); step();
    rst = 0;
    // LB with offset 1 sign-extends 0x80
    valid_i = 1; is_load_i = 1; data_mem_i = 32'h1234_80FF; addr_lo_i = 2'd1;
    load_code_i = 3'b000; addr_reg_wr_i = 5'd5; reg_wr_en_i = 1; ready_i = 0;
    #1 chk("lit_lb_bypass", {32'd0, data_bypass_o}, 64'h0000_0000_FFFF_FF80);
    step(); valid_i = 0;
    chk("lit_lb_data", {32'd0, data_reg_wr_o}, 64'h0000_0000_FFFF_FF80);
    chk("lit_lb_valid", {63'd0, valid_o}, 64'd1);
    // 64-bit LWU at offset 4, LD at offset 0
    m64 = 64'h8765_4321_DEAD_BEEF; lo64 = 3'd4; code64 = 3'b110;
    #1 chk("lit_lwu64", byp64, 64'h0000_0000_8765_4321);
    lo64 = 3'd0; code64 = 3'b011;
    #1 chk("lit_ld64", byp64, 64'h8765_4321_DEAD_BEEF);
    ready_i = 1; step(); step(); ready_i = 0;
    // Fill with A,B while stalled; C waits upstream
    beat(5'd1, 32'hA); step();
    beat(5'd2, 32'hB); step();
    chk("lit_full_ready", {63'd0, ready_o}, 64'd0);
    beat(5'd3, 32'hC); step(); step();
    ready_i = 1; step();
    chk("lit_drainA_data", {32'd0, data_reg_wr_o}, 64'hB);
    step(); valid_i = 0;
    chk("lit_drainB_data", {32'd0, data_reg_wr_o}, 64'hC);
    step(); step();
    // Steady push+pop at one entry
    beat(5'd4, 32'h100); ready_i = 0; step(); ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      beat(5'd4, 32'h101 + i); step();
      chk("lit_ss_ready", {63'd0, ready_o}, 64'd1);
      chk("lit_ss_data", {32'd0, data_reg_wr_o}, 64'h101 + i);
    end
    valid_i = 0; step(); ready_i = 0;
    // Flush while full drops the same-cycle beat
    beat(5'd6, 32'h600); step(); beat(5'd7, 32'h700); step();
    beat(5'd8, 32'h800); flush_i = 1; step(); flush_i = 0; valid_i = 0;
    chk("lit_flush_valid", {63'd0, valid_o}, 64'd0);
    // x0 destination never enables a write
    beat(5'd0, 32'h55); step(); valid_i = 0;
    chk("lit_x0_valid", {63'd0, valid_o}, 64'd1);
    chk("lit_x0_wen", {63'd0, reg_wr_en_o}, 64'd0);
    // Async reset mid-cycle while full
    beat(5'd9, 32'h900); step(); valid_i = 0;
    #2 rst = 1;
    #1;
    chk("lit_arst_valid", {63'd0, valid_o}, 64'd0);
    chk("lit_arst_wen", {63'd0, reg_wr_en_o}, 64'd0);
    chk("lit_arst_data", {32'd0, data_reg_wr_o}, 64'd0);
    chk("lit_arst_ready", {63'd0, ready_o}, 64'd1);
    step(); rst = 0;
    beat(5'd10, 32'hAAA); step(); valid_i = 0;
    chk("lit_post_rst", {32'd0, data_reg_wr_o}, 64'hAAA);
    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      valid_i       = ($urandom_range(0, 3) != 0);
      ready_i       = ($urandom_range(0, 2) != 0);
      flush_i       = ($urandom_range(0, 24) == 0);
      is_load_i     = $urandom_range(0, 1);
      data_mem_i    = $urandom;
      data_alu_i    = $urandom;
      addr_lo_i     = $urandom_range(0, 3);
      load_code_i   = $urandom_range(0, 7);
      addr_reg_wr_i = $urandom_range(0, 31);
      reg_wr_en_i   = $urandom_range(0, 1);
      m64           = {$urandom, $urandom};
      alu64         = {$urandom, $urandom};
      lo64          = $urandom_range(0, 7);
      code64        = $urandom_range(0, 7);
      ld64          = ($urandom_range(0, 3) != 0);
      step();
    end
    valid_i = 0; flush_i = 0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
